btn_event_ctrl: RTL and testbench
=================================

BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 Parameter LONG_CNT, default 100_000_000, hold length in clk cycles that classifies a press as long (1 s at 100 MHz); legal range >= 2.
REQ-002 Parameter REPEAT_CNT, default 20_000_000, auto-repeat period in clk cycles after a long press; legal range >= 2.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 i_btn  input  4  debounced button levels, 1 = pressed, synchronous to clk.
REQ-006 o_short  output  4  one-cycle pulse per button: short press completed.
REQ-007 o_long  output  4  one-cycle pulse per button: long-press threshold reached.
REQ-008 o_repeat  output  4  one-cycle pulse per button: auto-repeat tick while held after long.
REQ-009 o_grant  output  2  index of the button currently owning the controller; valid when o_busy=1.
REQ-010 o_busy  output  1  high while a press is being tracked or release is pending.

Function
REQ-011 All outputs SHALL be registered; at most one bit of o_short|o_long|o_repeat SHALL be high in any cycle.
REQ-012 A 4-bit register btn_prev SHALL hold i_btn from the previous edge; rise[i] = i_btn[i] & ~btn_prev[i].
REQ-013 FSM states SHALL be IDLE, PRESS, HOLD, LOCK; one shared counter cnt, width $clog2(max(LONG_CNT,REPEAT_CNT)).
REQ-014 IDLE: if any rise bit is set, the block SHALL grant the lowest-index rising button g, load o_grant=g, clear cnt, and enter PRESS; otherwise it SHALL stay in IDLE with o_busy=0.
REQ-015 Simultaneous rises SHALL be arbitrated by fixed priority, bit 0 highest; non-granted buttons SHALL produce no event for that press.
REQ-016 PRESS: while i_btn[g]=1, cnt SHALL increment once per cycle; when cnt reaches LONG_CNT-1, the next cycle SHALL carry o_long[g]=1, cnt SHALL clear, and the state SHALL become HOLD.
REQ-017 PRESS: when i_btn[g]=0 is sampled, o_short[g] SHALL be high in the following cycle, and the state SHALL become LOCK.
REQ-018 HOLD: while i_btn[g]=1, cnt SHALL increment; at REPEAT_CNT-1 the next cycle SHALL carry o_repeat[g]=1 and cnt SHALL clear.
REQ-019 HOLD: release of g SHALL enter LOCK with no o_short pulse.
REQ-020 LOCK: the state SHALL return to IDLE on the first edge that samples i_btn==4'b0000; no events SHALL be generated in LOCK.
REQ-021 Non-granted buttons pressed or released during PRESS/HOLD/LOCK SHALL be ignored; because btn_prev tracks them, they SHALL NOT generate a rise on return to IDLE.
REQ-022 o_busy SHALL be 1 in PRESS, HOLD and LOCK, and 0 in IDLE.
REQ-023 If release of g and the long threshold occur on the same edge, the release SHALL win: o_short[g] pulses and o_long does not.
REQ-024 The counter SHALL never wrap: it clears on every threshold hit and on every state change.

Reset
REQ-025 When rst=0 is sampled, the block SHALL enter IDLE, clear cnt, and drive o_short=o_long=o_repeat=4'b0, o_grant=2'd0, o_busy=0.
REQ-026 During reset, btn_prev SHALL load 4'b1111, so that buttons held through reset produce no event until they are released and pressed again.
REQ-027 Reset asserted mid-press SHALL abort the press with no pulse emitted, either in the reset cycle or after it.

Verification (LONG_CNT=5, REPEAT_CNT=3)
REQ-028 Short press: assert i_btn=4'b0010 for 3 cycles, then 0 -> exactly one o_short=4'b0010 pulse one cycle after release is sampled, o_grant=1, no o_long.
REQ-029 Long press with repeat: hold i_btn[0] for 12 cycles -> o_long[0] one cycle after the 5th high sample, then o_repeat[0] every 3 cycles while held, and no o_short on release.
REQ-030 Priority: i_btn goes 0000 -> 1100 in one edge and is held for 2 cycles -> o_grant=2, one o_short=4'b0100 pulse, and no event for bit 3 after all buttons are released.
REQ-031 Lock: press btn0 and release it while btn1 is held -> o_short[0], o_busy stays 1 until btn1 is released, and btn1 gives no event.
REQ-032 Reset interactions: hold btn2 through reset release -> no events and o_busy=0; then release and re-press btn2 -> normal short press. Separately, assert rst=0 in PRESS at cnt=3 -> all outputs 0 the next cycle and no later o_long.

Source files
------------

// File: rtl/btn_event_ctrl_if.sv
// Button controller bus: debounced button levels in, event pulses and
// ownership status out.
interface btn_event_ctrl_if;
    logic [3:0] i_btn;
    logic [3:0] o_short;
    logic [3:0] o_long;
    logic [3:0] o_repeat;
    logic [1:0] o_grant;
    logic       o_busy;

    modport master (
        output i_btn,
        input  o_short,
        input  o_long,
        input  o_repeat,
        input  o_grant,
        input  o_busy
    );

    modport slave (
        input  i_btn,
        output o_short,
        output o_long,
        output o_repeat,
        output o_grant,
        output o_busy
    );
endinterface

// File: rtl/btn_event_ctrl.sv
// Four-button press classifier: one button owns the controller at a time and
// gets short / long / auto-repeat pulses; all outputs are registered.
module btn_event_ctrl #(
    parameter int unsigned LONG_CNT   = 100_000_000,
    parameter int unsigned REPEAT_CNT = 20_000_000
) (
    input  logic               clk,
    input  logic               rst,
    btn_event_ctrl_if.slave    bus
);

    localparam int unsigned CNT_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    // The rising sample that grants the press already counts as the first
    // held cycle, so PRESS fires one count earlier than HOLD does.
    localparam logic [CNT_W-1:0] LONG_HIT = CNT_W'(LONG_CNT - 2);
    localparam logic [CNT_W-1:0] REP_HIT  = CNT_W'(REPEAT_CNT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_LOCK  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       grant_q, grant_d;
    logic [3:0]       btn_prev_q, btn_prev_d;
    logic [3:0]       short_q, short_d;
    logic [3:0]       long_q, long_d;
    logic [3:0]       repeat_q, repeat_d;
    logic             busy_q, busy_d;

    logic [3:0]       rise;
    logic [3:0]       grant_oh;
    logic             g_held;

    // Next-state, counter and event decode for the owning button.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        btn_prev_d = bus.i_btn;
        short_d    = '0;
        long_d     = '0;
        repeat_d   = '0;

        rise     = bus.i_btn & ~btn_prev_q;
        grant_oh = 4'b0001 << grant_q;
        g_held   = bus.i_btn[grant_q];

        case (state_q)
            ST_IDLE: begin
                if (|rise) begin
                    state_d = ST_PRESS;
                    cnt_d   = '0;
                    if (rise[0])      grant_d = 2'd0;
                    else if (rise[1]) grant_d = 2'd1;
                    else if (rise[2]) grant_d = 2'd2;
                    else              grant_d = 2'd3;
                end
            end
            ST_PRESS: begin
                // Release is tested first so it wins over a coincident threshold.
                if (!g_held) begin
                    short_d = grant_oh;
                    state_d = ST_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_HIT) begin
                    long_d  = grant_oh;
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!g_held) begin
                    state_d = ST_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == REP_HIT) begin
                    repeat_d = grant_oh;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOCK: begin
                if (bus.i_btn == 4'b0000) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Register update; reset preloads btn_prev so held buttons need a re-press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            grant_q    <= '0;
            btn_prev_q <= '1;
            short_q    <= '0;
            long_q     <= '0;
            repeat_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            btn_prev_q <= btn_prev_d;
            short_q    <= short_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_short  = short_q;
    assign bus.o_long   = long_q;
    assign bus.o_repeat = repeat_q;
    assign bus.o_grant  = grant_q;
    assign bus.o_busy   = busy_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed scenarios plus random button traffic,
// compared cycle by cycle against a press-history reference model.
module tb_btn_event_ctrl;

    localparam int unsigned LONG = 5;
    localparam int unsigned REP  = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    btn_event_ctrl_if bus ();

    btn_event_ctrl #(
        .LONG_CNT   (LONG),
        .REPEAT_CNT (REP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: owner, count of high samples since the grant, and
    // whether the press has finished and is waiting for all-release.
    bit         m_active = 1'b0;
    bit         m_locked = 1'b0;
    int         m_grant  = 0;
    int         m_k      = 0;
    logic [3:0] m_prev   = 4'b1111;
    logic [3:0] exp_short, exp_long, exp_rep;
    logic       exp_busy;
    logic [1:0] exp_grant;

    int unsigned seen_short, seen_long, seen_rep;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic [3:0] b, input logic r);
        logic [3:0] rise;
        exp_short = '0;
        exp_long  = '0;
        exp_rep   = '0;
        if (!r) begin
            m_active = 1'b0;
            m_locked = 1'b0;
            m_grant  = 0;
            m_prev   = 4'b1111;
        end else begin
            rise = b & ~m_prev;
            if (!m_active) begin
                if (rise != 4'b0000) begin
                    for (int i = 3; i >= 0; i--)
                        if (rise[i]) m_grant = i;
                    m_active = 1'b1;
                    m_locked = 1'b0;
                    m_k      = 1;
                end
            end else if (!m_locked) begin
                if (!b[m_grant]) begin
                    if (m_k < int'(LONG)) exp_short = 4'b0001 << m_grant;
                    m_locked = 1'b1;
                end else begin
                    m_k++;
                    if (m_k == int'(LONG))
                        exp_long = 4'b0001 << m_grant;
                    else if (m_k > int'(LONG) && ((m_k - int'(LONG)) % int'(REP)) == 0)
                        exp_rep = 4'b0001 << m_grant;
                end
            end else if (b == 4'b0000) begin
                m_active = 1'b0;
            end
            m_prev = b;
        end
        exp_busy  = m_active;
        exp_grant = 2'(m_grant);
    endtask

    task automatic step(input logic [3:0] b, input logic r);
        bus.i_btn = b;
        rst       = r;
        @(posedge clk);
        model_update(b, r);
        #1;
        check("short",  32'(bus.o_short),  32'(exp_short));
        check("long",   32'(bus.o_long),   32'(exp_long));
        check("repeat", 32'(bus.o_repeat), 32'(exp_rep));
        check("busy",   32'(bus.o_busy),   32'(exp_busy));
        if (exp_busy || !r) check("grant", 32'(bus.o_grant), 32'(exp_grant));
        check("onehot", 32'($countones(bus.o_short | bus.o_long | bus.o_repeat) <= 1), 32'd1);
        seen_short += 32'($countones(bus.o_short));
        seen_long  += 32'($countones(bus.o_long));
        seen_rep   += 32'($countones(bus.o_repeat));
    endtask

    task automatic clear_seen();
        seen_short = 0;
        seen_long  = 0;
        seen_rep   = 0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(4'b0000, 1'b1);
    endtask

    initial begin
        logic [3:0]  b;
        int unsigned len;
        clear_seen();

        // Reset state
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        idle(2);

        // Short press on button 1
        clear_seen();
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b1);
        idle(3);
        check("s_short_cnt", seen_short, 1);
        check("s_long_cnt",  seen_long,  0);

        // Long press with auto-repeat on button 0
        clear_seen();
        for (int i = 0; i < 12; i++) step(4'b0001, 1'b1);
        idle(3);
        check("l_long_cnt",  seen_long,  1);
        check("l_rep_cnt",   seen_rep,   2);
        check("l_short_cnt", seen_short, 0);

        // Simultaneous rise: bit 2 beats bit 3
        clear_seen();
        for (int i = 0; i < 2; i++) step(4'b1100, 1'b1);
        idle(4);
        check("p_short_cnt", seen_short, 1);
        check("p_total_cnt", seen_short + seen_long + seen_rep, 1);

        // Lock: btn0 released while btn1 still held
        clear_seen();
        step(4'b0001, 1'b1);
        step(4'b0011, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0010, 1'b1);
        idle(4);
        check("k_short_cnt", seen_short, 1);
        check("k_total_cnt", seen_short + seen_long + seen_rep, 1);

        // Button held through reset, then a fresh press
        clear_seen();
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        for (int i = 0; i < 8; i++) step(4'b0100, 1'b1);
        check("r_held_events", seen_short + seen_long + seen_rep, 0);
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        idle(3);
        check("r_repress_short", seen_short, 1);

        // Reset mid-press just before the long threshold
        clear_seen();
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b1);
        step(4'b0001, 1'b0);
        for (int i = 0; i < 8; i++) step(4'b0001, 1'b1);
        idle(3);
        check("a_abort_events", seen_short + seen_long + seen_rep, 0);

        // Random traffic
        for (int unsigned seg = 0; seg < 400; seg++) begin
            case ($urandom_range(0, 3))
                0:       b = 4'b0000;
                1:       b = 4'b0001 << $urandom_range(0, 3);
                default: b = 4'($urandom_range(0, 15));
            endcase
            len = $urandom_range(1, 12);
            for (int unsigned i = 0; i < len; i++)
                step(b, ($urandom_range(0, 79) != 0));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
